// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the single-cycle datapath.
// Issues word-aligned fetches under a credit limit, keeps a PC tag queue for
// in-flight requests, buffers returned words in a DEPTH-entry prefetch FIFO
// and flushes on redirect (responses still in flight are counted and dropped).
// Optional build macro FETCH_PERF_EN adds saturating stall/flush counters.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,            // power of two, >= 2
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  outstanding_q, outstanding_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  tag_wr_q, tag_wr_d;
    logic [AW-1:0]  tag_rd_q, tag_rd_d;

    logic [31:0]    data_mem [DEPTH];
    logic [31:0]    pc_mem   [DEPTH];
    logic [31:0]    tag_mem  [DEPTH];

    logic           req_fire;
    logic           push;
    logic           pop;
    logic           drop_active;
    logic [CW:0]    credit_used;

    // Buffered words plus words still owed by memory may never exceed DEPTH,
    // so every response that is kept is guaranteed a FIFO slot.
    assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req    = rst_n & ~redirect & (credit_used < DEPTH_W);
    assign imem_addr   = fetch_pc_q;
    assign req_fire    = imem_req & imem_gnt;

    // A response is discarded while drop credits remain or during a redirect.
    assign drop_active = (drop_q != '0);
    assign push        = imem_rvalid & ~drop_active & ~redirect;

    // Head is gated to zero when empty so the outputs read 0 out of reset.
    assign inst_valid  = (count_q != '0);
    assign pop         = inst_valid & inst_ready & ~redirect;
    assign inst_data   = inst_valid ? data_mem[rd_ptr_q] : '0;
    assign inst_pc     = inst_valid ? pc_mem[rd_ptr_q]   : '0;

    // Next-state for fetch PC, credit counters and FIFO/tag pointers.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rvalid);
        drop_d        = drop_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        // The tag queue follows every request/response, including dropped ones.
        tag_wr_d      = tag_wr_q + AW'(req_fire);
        tag_rd_d      = tag_rd_q + AW'(imem_rvalid);
        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            // Everything still in flight after this cycle belongs to the old path.
            drop_d     = outstanding_q - CW'(imem_rvalid);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid && drop_active) begin
                drop_d = drop_q - CW'(1);
            end
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
        end
    end

    // Storage arrays: tag written on grant, FIFO entry written on kept response.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= tag_mem[tag_rd_q];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: starved cycles (no redirect) and redirect cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!inst_valid && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers share the asynchronous reset of the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit. An in-order
// memory responder with selectable latency serves requests; the reference model
// states that delivered PCs form a contiguous +4 stream starting at RESET_PC or
// at the latest redirect target, and each word equals mem_word(pc).
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_pass;
    int          cyc;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_req_addr;
    logic [31:0] exp_pc;
    bit          after_redir;
    bit          prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_data;
    int          lat_lo;
    int          lat_hi;
    int          pops;
    logic [31:0] first_pop_pc;
    int          first_gnt_cyc;
    int          first_valid_cyc;
    int          valid_cycles;
    int          redir_cnt;
    logic [31:0] saved_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs on the falling edge, check, update model.
    task automatic cycle(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt    = gnt;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        check("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (imem_req) begin
            check("req_addr", imem_addr, exp_req_addr);
            check("credit_limit", 32'(mq_addr.size() < DEPTH), 32'd1);
        end
        if (redir) check("req_during_redirect", 32'(imem_req), 32'd0);
        if (after_redir) check("valid_after_redirect", 32'(inst_valid), 32'd0);
        if (prev_hold) begin
            check("hold_valid", 32'(inst_valid), 32'd1);
            check("hold_pc", inst_pc, prev_pc);
            check("hold_data", inst_data, prev_data);
        end
        if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (inst_valid) valid_cycles++;
        if (inst_valid && rdy && !redir) begin
            check("pop_pc", inst_pc, exp_pc);
            check("pop_data", inst_data, mem_word(exp_pc));
            if (pops == 0) first_pop_pc = inst_pc;
            pops++;
            exp_pc = exp_pc + 32'd4;
        end
        prev_hold = inst_valid && !rdy && !redir;
        prev_pc   = inst_pc;
        prev_data = inst_data;
        if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req && gnt) begin
            mq_addr.push_back(exp_req_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            exp_req_addr = exp_req_addr + 32'd4;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        end
        if (redir) begin
            exp_req_addr = {rpc[31:2], 2'b00};
            exp_pc       = {rpc[31:2], 2'b00};
            redir_cnt++;
        end
        after_redir = redir;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0;
        exp_req_addr = RESET_PC; exp_pc = RESET_PC;
        after_redir = 0; prev_hold = 0; prev_pc = '0; prev_data = '0;
        lat_lo = 1; lat_hi = 1; pops = 0; first_pop_pc = '0;
        first_gnt_cyc = -1; first_valid_cyc = -1; valid_cycles = 0; redir_cnt = 0;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset values
        #12;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_data", inst_data, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at 1-cycle latency: wrap through 0, latency 2, no gaps
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, '0);
        check("first_valid_latency", 32'(first_valid_cyc - first_gnt_cyc), 32'd2);
        check("first_pop_wrap_start", first_pop_pc, RESET_PC);
        valid_cycles = 0; pops = 0;
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, '0);
        check("no_gaps_valid", 32'(valid_cycles), 32'd10);
        check("no_gaps_pops", 32'(pops), 32'd10);

        // Backpressure: FIFO fills to DEPTH, requests stop, head held
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, '0);
        #1;
        check("full_req_off", 32'(imem_req), 32'd0);
        check("full_head_valid", 32'(inst_valid), 32'd1);
        check("full_head_pc", inst_pc, exp_pc);
        pops = 0;
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0);
        check("buffered_words", 32'(pops), 32'(DEPTH));
        #1;
        check("drained_valid", 32'(inst_valid), 32'd0);

        // Grant withheld: address stable, no push
        saved_addr = exp_req_addr;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, '0);
            #1;
            check("nogt_addr_stable", imem_addr, saved_addr);
            check("nogt_req", 32'(imem_req), 32'd1);
            check("nogt_no_push", 32'(inst_valid), 32'd0);
        end

        // Redirect with two requests in flight
        lat_lo = 5; lat_hi = 5;
        cycle(1, 1, 0, '0);
        cycle(1, 1, 0, '0);
        check("inflight_before_redirect", 32'(mq_addr.size()), 32'd2);
        cycle(1, 1, 1, 32'h0000_0103);
        #1;
        check("redirect_next_addr", imem_addr, 32'h0000_0100);
        lat_lo = 1; lat_hi = 1; pops = 0;
        for (int i = 0; i < 14; i++) cycle(1, 1, 0, '0);
        check("redirect_first_pc", first_pop_pc, 32'h0000_0100);

        // Back-to-back redirects: last target wins
        lat_lo = 3; lat_hi = 3;
        cycle(1, 1, 0, '0);
        cycle(1, 1, 0, '0);
        cycle(1, 1, 1, 32'h0000_0200);
        cycle(1, 1, 1, 32'h0000_0302);
        lat_lo = 1; lat_hi = 1; pops = 0;
        for (int i = 0; i < 15; i++) cycle(1, 1, 0, '0);
        check("b2b_redirect_first_pc", first_pop_pc, 32'h0000_0300);

        // Randomized traffic with variable latency
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0, $urandom);
        end
`ifdef FETCH_PERF_EN
        check("flush_cnt", flush_cnt, 32'(redir_cnt));
`endif

        // Mid-stream reset with a full FIFO
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, '0);
        @(negedge clk);
        rst_n = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b0;
        #1;
        check("midrst_valid", 32'(inst_valid), 32'd0);
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_addr", imem_addr, RESET_PC);
`ifdef FETCH_PERF_EN
        check("midrst_stall_cnt", stall_cnt, 32'd0);
        check("midrst_flush_cnt", flush_cnt, 32'd0);
`endif
        mq_addr.delete(); mq_due.delete();
        exp_req_addr = RESET_PC; exp_pc = RESET_PC;
        after_redir = 0; prev_hold = 0; redir_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        pops = 0;
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, '0);
        check("restart_first_pc", first_pop_pc, RESET_PC);
        check("restart_pops", 32'(pops), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
